// File: rtl/prdct_chk_pkg.sv
// Shared definitions for the EX-stage prediction checker: opcode and funct3
// codes, reset address, jump-enable encodings, checker state encoding and
// immediate decode helpers.
package prdct_chk_pkg;

  // Control-transfer opcodes
  localparam logic [6:0] INST_TYPE_B = 7'b1100011;
  localparam logic [6:0] INST_JAL    = 7'b1101111;
  localparam logic [6:0] INST_JALR   = 7'b1100111;

  // Branch funct3 codes
  localparam logic [2:0] INST_BEQ  = 3'b000;
  localparam logic [2:0] INST_BNE  = 3'b001;
  localparam logic [2:0] INST_BLT  = 3'b100;
  localparam logic [2:0] INST_BGE  = 3'b101;
  localparam logic [2:0] INST_BLTU = 3'b110;
  localparam logic [2:0] INST_BGEU = 3'b111;

  // Core-wide constants
  localparam logic [31:0] CpuResetAddr = 32'h0000_0000;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic        JumpEnable   = 1'b1;
  localparam logic        JumpDisable  = 1'b0;

  // Checker state: IDLE resolves, SHADOW masks the squashed wrong-path slot
  typedef enum logic {
    IDLE   = 1'b0,
    SHADOW = 1'b1
  } state_t;

  // B-type immediate, sign-extended to 32 bits
  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  // J-type immediate, sign-extended to 32 bits
  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  // I-type immediate, sign-extended to 32 bits
  function automatic logic [31:0] imm_i(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:20]};
  endfunction

endpackage

// File: rtl/prdct_chk_cmp.sv
// Combinational branch comparator: turns funct3 and the two forwarded
// operands into the actual branch direction. Unused funct3 codes are
// treated as not taken.
module prdct_chk_cmp
  import prdct_chk_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] rs1,
  input  logic [DATA_W-1:0] rs2,
  output logic              taken
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (rs1 == rs2);
  assign lt_s = ($signed(rs1) < $signed(rs2));
  assign lt_u = (rs1 < rs2);

  // Select the comparison that matches the branch flavour
  always_comb begin
    taken = 1'b0;
    case (funct3)
      INST_BEQ:  taken = eq;
      INST_BNE:  taken = ~eq;
      INST_BLT:  taken = lt_s;
      INST_BGE:  taken = ~lt_s;
      INST_BLTU: taken = lt_u;
      INST_BGEU: taken = ~lt_u;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/prdct_chk.sv
// EX-stage branch resolution and prediction checker. Resolves B/JAL/JALR,
// compares against the ID-stage prediction and issues a registered redirect
// plus flush on a mispredict, then masks one wrong-path shadow cycle.
// Optional performance counters are built when PRDCT_PERF_CNT_EN is defined.
module prdct_chk
  import prdct_chk_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ex_valid_i,
  input  logic              hold_i,
  input  logic [31:0]       ex_inst_i,
  input  logic [ADDR_W-1:0] ex_instaddr_i,
  input  logic [DATA_W-1:0] ex_rs1_data_i,
  input  logic [DATA_W-1:0] ex_rs2_data_i,
  input  logic              ex_prd_jump_en_i,
  input  logic [ADDR_W-1:0] ex_prd_target_i,
  output logic              redirect_en_o,
  output logic [ADDR_W-1:0] redirect_addr_o,
  output logic              flush_o,
  output logic [CNT_W-1:0]  br_cnt_o,
  output logic [CNT_W-1:0]  mispred_cnt_o
);

  state_t            state;
  state_t            state_next;
  logic              redirect_en_next;
  logic              flush_next;
  logic [ADDR_W-1:0] redirect_addr_next;

  logic [6:0]        opcode;
  logic              br_taken;
  logic              resolve;
  logic              mispred;
  logic [ADDR_W-1:0] act_target;

  logic [ADDR_W-1:0] off_b;
  logic [ADDR_W-1:0] off_j;
  logic [ADDR_W-1:0] off_i;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] jal_target;
  logic [ADDR_W-1:0] jalr_sum;
  logic [ADDR_W-1:0] jalr_target;

  assign opcode = ex_inst_i[6:0];

  prdct_chk_cmp #(
    .DATA_W (DATA_W)
  ) u_cmp (
    .funct3 (ex_inst_i[14:12]),
    .rs1    (ex_rs1_data_i),
    .rs2    (ex_rs2_data_i),
    .taken  (br_taken)
  );

  // Candidate targets; all address math wraps modulo 2^ADDR_W
  assign off_b       = ADDR_W'($signed(imm_b(ex_inst_i)));
  assign off_j       = ADDR_W'($signed(imm_j(ex_inst_i)));
  assign off_i       = ADDR_W'($signed(imm_i(ex_inst_i)));
  assign pc_plus4    = ex_instaddr_i + ADDR_W'(4);
  assign br_target   = ex_instaddr_i + off_b;
  assign jal_target  = ex_instaddr_i + off_j;
  assign jalr_sum    = ADDR_W'(ex_rs1_data_i) + off_i;
  assign jalr_target = {jalr_sum[ADDR_W-1:1], 1'b0};

  // Only a live, unstalled instruction outside the shadow slot is resolved
  assign resolve = ex_valid_i & ~hold_i & (state == IDLE);

  // Decide direction/target per opcode and whether the prediction was wrong
  always_comb begin
    mispred    = 1'b0;
    act_target = pc_plus4;
    case (opcode)
      INST_TYPE_B: begin
        mispred    = (br_taken != ex_prd_jump_en_i);
        act_target = br_taken ? br_target : pc_plus4;
      end
      INST_JAL: begin
        mispred    = (ex_prd_jump_en_i == JumpDisable);
        act_target = jal_target;
      end
      INST_JALR: begin
        mispred    = (ex_prd_jump_en_i == JumpDisable) ||
                     (ex_prd_target_i != jalr_target);
        act_target = jalr_target;
      end
      default: begin
        mispred    = 1'b0;
        act_target = pc_plus4;
      end
    endcase
  end

  // Next-state and next-output logic; pulses last exactly one cycle
  always_comb begin
    state_next         = state;
    redirect_en_next   = 1'b0;
    flush_next         = 1'b0;
    redirect_addr_next = redirect_addr_o;
    case (state)
      IDLE: begin
        if (resolve && mispred) begin
          state_next         = SHADOW;
          redirect_en_next   = 1'b1;
          flush_next         = 1'b1;
          redirect_addr_next = act_target;
        end
      end
      SHADOW: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and registered redirect/flush outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= IDLE;
      redirect_en_o   <= 1'b0;
      flush_o         <= 1'b0;
      redirect_addr_o <= ADDR_W'(CpuResetAddr);
    end else begin
      state           <= state_next;
      redirect_en_o   <= redirect_en_next;
      flush_o         <= flush_next;
      redirect_addr_o <= redirect_addr_next;
    end
  end

`ifdef PRDCT_PERF_CNT_EN
  logic             is_ctrl;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  assign is_ctrl = (opcode == INST_TYPE_B) || (opcode == INST_JAL) ||
                   (opcode == INST_JALR);

  // Saturating counters of resolved control transfers and mispredicts
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      br_cnt      <= '0;
      mispred_cnt <= '0;
    end else begin
      if (resolve && is_ctrl && (br_cnt != '1)) begin
        br_cnt <= br_cnt + CNT_W'(1);
      end
      if (resolve && mispred && (mispred_cnt != '1)) begin
        mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
    end
  end

  assign br_cnt_o      = br_cnt;
  assign mispred_cnt_o = mispred_cnt;
`else
  assign br_cnt_o      = CNT_W'(ZeroWord);
  assign mispred_cnt_o = CNT_W'(ZeroWord);
`endif

endmodule
